// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: the renderer owns the port, game-logic requesters get round-robin
// single accesses in blanking. Define VRAM_ARB_VBLANK_ONLY_EN to restrict logic to vertical blanking.
module vram_arbiter #(
  parameter int NREQ  = 3,
  parameter int ADDRW = 12,
  parameter int DATAW = 8
) (
  input  logic                    clk_pix,
  input  logic                    rst_n,
  input  logic                    de,
  input  logic                    line,
  input  logic                    frame,
  input  logic                    rd_req,
  input  logic [ADDRW-1:0]        rd_addr,
  output logic                    rd_valid,
  output logic [DATAW-1:0]        rd_data,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         req_we,
  input  logic [NREQ*ADDRW-1:0]   req_addr,
  input  logic [NREQ*DATAW-1:0]   req_wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic [DATAW-1:0]        req_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDRW-1:0]        mem_addr,
  output logic [DATAW-1:0]        mem_wdata,
  input  logic [DATAW-1:0]        mem_rdata,
  output logic [15:0]             stall_last
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr, cur_idx, pick_idx;
  logic            pick_ok, open, start, grant_now, stall_inc, rd_pend;
  logic [15:0]     stall_cnt;
  logic [NREQ-1:0] gnt_d, done_d;
  logic            mem_en_d, mem_we_d;
  logic [ADDRW-1:0] mem_addr_d;
  logic [DATAW-1:0] mem_wdata_d;

`ifdef VRAM_ARB_VBLANK_ONLY_EN
  logic vblank, vblank_eff;

  // frame wins over line so the first cycle of a frame already counts as vertical blanking
  always_comb begin
    vblank_eff = vblank;
    if (line)  vblank_eff = 1'b0;
    if (frame) vblank_eff = 1'b1;
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_n) vblank <= 1'b0;
    else        vblank <= vblank_eff;
  end

  assign open = !de && vblank_eff;
`else
  logic unused_line;
  assign unused_line = line;
  assign open        = !de;
`endif

  assign start = open && !rd_req;

  // First set request bit at or after rr_ptr, searching modulo NREQ
  always_comb begin
    int j;
    // NOTE: every always_comb output gets a default up front so no path can infer a latch.
    pick_ok  = 1'b0;
    pick_idx = '0;
    j        = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(rr_ptr) + k) % NREQ;
      if (!pick_ok && req[j]) begin
        pick_ok  = 1'b1;
        pick_idx = IW'(j);
      end
    end
  end

  assign grant_now = (state == IDLE) && start && pick_ok;
  assign stall_inc = (state == IDLE) && (|req) && !grant_now;

  // State register
  always_ff @(posedge clk_pix) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      cur_idx <= '0;
    end else begin
      state <= state_nxt;
      if (grant_now) cur_idx <= pick_idx;
      if (state == ISSUE) rr_ptr <= (int'(cur_idx) == NREQ-1) ? '0 : cur_idx + 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start && pick_ok) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs
  always_comb begin
    gnt_d       = '0;
    done_d      = '0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if (grant_now) begin
      gnt_d[pick_idx] = 1'b1;
      mem_en_d        = 1'b1;
      mem_we_d        = req_we[pick_idx];
      mem_addr_d      = req_addr[int'(pick_idx)*ADDRW +: ADDRW];
      mem_wdata_d     = req_wdata[int'(pick_idx)*DATAW +: DATAW];
    end else if (rd_req) begin
      mem_en_d   = 1'b1;
      mem_addr_d = rd_addr;
    end
    if (state == ISSUE) done_d[cur_idx] = 1'b1;
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      gnt       <= '0;
      done      <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_pend   <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      gnt       <= gnt_d;
      done      <= done_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      rd_pend   <= rd_req;
      rd_valid  <= rd_pend;
    end
  end

  // RAM output is already a register; gating it with the registered valids gives clean zeros
  assign rd_data   = rd_valid ? mem_rdata : '0;
  assign req_rdata = (|done)  ? mem_rdata : '0;

  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      stall_last <= '0;
    end else if (frame) begin
      stall_last <= stall_cnt;
      stall_cnt  <= stall_inc ? 16'd1 : 16'd0;
    end else if (stall_inc && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: a cycle-scheduled behavioural model plus directed scenarios.
module tb_vram_arbiter;

  localparam int NREQ  = 3;
  localparam int ADDRW = 12;
  localparam int DATAW = 8;

  logic                  clk_pix = 1'b0;
  logic                  rst_n   = 1'b0;
  logic                  de      = 1'b0;
  logic                  line    = 1'b0;
  logic                  frame   = 1'b0;
  logic                  rd_req  = 1'b0;
  logic [ADDRW-1:0]      rd_addr = '0;
  logic                  rd_valid;
  logic [DATAW-1:0]      rd_data;
  logic [NREQ-1:0]       req     = '0;
  logic [NREQ-1:0]       req_we  = '0;
  logic [NREQ*ADDRW-1:0] req_addr  = '0;
  logic [NREQ*DATAW-1:0] req_wdata = '0;
  logic [NREQ-1:0]       gnt, done;
  logic [DATAW-1:0]      req_rdata;
  logic                  mem_en, mem_we;
  logic [ADDRW-1:0]      mem_addr;
  logic [DATAW-1:0]      mem_wdata;
  logic [DATAW-1:0]      mem_rdata = '0;
  logic [15:0]           stall_last;

  always #5 clk_pix = ~clk_pix;

  vram_arbiter #(.NREQ(NREQ), .ADDRW(ADDRW), .DATAW(DATAW)) dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .de(de), .line(line), .frame(frame),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .req_rdata(req_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_last(stall_last)
  );

  // Synchronous RAM with one cycle of read latency
  logic [DATAW-1:0] ram       [1<<ADDRW];
  logic [DATAW-1:0] model_mem [1<<ADDRW];

  always @(posedge clk_pix) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what must be visible after each edge, scheduled from the access rules
  typedef struct packed {
    logic [NREQ-1:0]  gnt;
    logic [NREQ-1:0]  done;
    logic             mem_en;
    logic             mem_we;
    logic [ADDRW-1:0] addr;
    logic [DATAW-1:0] wdata;
    logic             rd_valid;
    logic [DATAW-1:0] rd_data;
    logic             lread;
    logic [DATAW-1:0] rdata;
  } exp_t;

  exp_t cur, nxt;
  int   ptr, edge_n, next_ok, stall_cnt_m, stall_last_m;
  bit   vb_m, live;

  always @(posedge clk_pix) begin
    bit               open_m, waiting;
    int               pick;
    logic [ADDRW-1:0] a;
    logic [DATAW-1:0] w;
    live = 1'b1;
    if (!rst_n) begin
      cur = '0; nxt = '0; ptr = 0; edge_n = 0; next_ok = 0;
      stall_cnt_m = 0; stall_last_m = 0; vb_m = 1'b0;
    end else begin
      cur = nxt;
      nxt = '0;
`ifdef VRAM_ARB_VBLANK_ONLY_EN
      if (frame)     vb_m = 1'b1;
      else if (line) vb_m = 1'b0;
      open_m = !de && vb_m;
`else
      open_m = !de;
`endif
      pick = -1;
      if (open_m && !rd_req && edge_n >= next_ok)
        for (int k = 0; k < NREQ; k++)
          if (pick < 0 && req[(ptr + k) % NREQ]) pick = (ptr + k) % NREQ;
      if (pick >= 0) begin
        a = req_addr[pick*ADDRW +: ADDRW];
        w = req_wdata[pick*DATAW +: DATAW];
        cur.gnt    = NREQ'(1) << pick;
        cur.mem_en = 1'b1;
        cur.mem_we = req_we[pick];
        cur.addr   = a;
        cur.wdata  = w;
        nxt.done   = NREQ'(1) << pick;
        nxt.lread  = !req_we[pick];
        nxt.rdata  = model_mem[a];
        if (req_we[pick]) model_mem[a] = w;
        ptr     = (pick + 1) % NREQ;
        next_ok = edge_n + 3;
      end
      if (rd_req) begin
        cur.mem_en   = 1'b1;
        cur.mem_we   = 1'b0;
        cur.addr     = rd_addr;
        nxt.rd_valid = 1'b1;
        nxt.rd_data  = model_mem[rd_addr];
      end
      waiting = (|req) && (edge_n >= next_ok) && (pick < 0);
      if (frame) begin
        stall_last_m = stall_cnt_m;
        stall_cnt_m  = waiting ? 1 : 0;
      end else if (waiting && stall_cnt_m < 65535) begin
        stall_cnt_m++;
      end
      edge_n++;
    end
  end

  always @(negedge clk_pix) begin
    if (live) begin
      check("gnt", 32'(gnt), 32'(cur.gnt));
      check("done", 32'(done), 32'(cur.done));
      check("mem_en", 32'(mem_en), 32'(cur.mem_en));
      if (cur.mem_en) begin
        check("mem_we", 32'(mem_we), 32'(cur.mem_we));
        check("mem_addr", 32'(mem_addr), 32'(cur.addr));
        if (cur.mem_we) check("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
      end
      check("rd_valid", 32'(rd_valid), 32'(cur.rd_valid));
      if (cur.rd_valid) check("rd_data", 32'(rd_data), 32'(cur.rd_data));
      if (cur.done != '0 && cur.lread) check("req_rdata", 32'(req_rdata), 32'(cur.rdata));
      check("stall_last", 32'(stall_last), 32'(stall_last_m));
    end
  end

  task automatic tick();
    @(posedge clk_pix);
    @(negedge clk_pix);
  endtask

  task automatic set_req(input int i, input logic we, input logic [ADDRW-1:0] a,
                         input logic [DATAW-1:0] d);
    req_we[i]                  = we;
    req_addr[i*ADDRW +: ADDRW] = a;
    req_wdata[i*DATAW +: DATAW] = d;
  endtask

  task automatic frame_pulse();
    frame = 1'b1;
    tick();
    frame = 1'b0;
  endtask

  initial begin
    logic [NREQ-1:0]  gseq [4];
    logic [DATAW-1:0] wseq [4];
    int ng, gseen;

    for (int i = 0; i < (1 << ADDRW); i++) begin
      ram[i]       = DATAW'(i * 7 + 3);
      model_mem[i] = DATAW'(i * 7 + 3);
    end
    ram[16]       = 8'hA5;
    model_mem[16] = 8'hA5;

    // Reset state
    tick(); tick();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_done", 32'(done), 0);
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_req_rdata", 32'(req_rdata), 0);
    check("rst_stall_last", 32'(stall_last), 0);
    rst_n = 1'b1;
    frame_pulse();

    // Single logic read in blanking
    set_req(0, 1'b0, 12'h010, 8'h00);
    req = 3'b001;
    tick();
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_mem_addr", 32'(mem_addr), 32'h010);
    check("t1_mem_we", 32'(mem_we), 0);
    tick();
    check("t1_done", 32'(done), 32'h1);
    check("t1_rdata", 32'(req_rdata), 32'hA5);
    req = '0;
    tick(); tick();

    // Round-robin rotation with all three requesters writing
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    frame_pulse();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, ADDRW'(12'h100 + i), DATAW'(8'hC0 + i));
    req = 3'b111;
    ng  = 0;
    for (int t = 0; t < 11; t++) begin
      tick();
      if (gnt != '0 && ng < 4) begin
        gseq[ng] = gnt;
        wseq[ng] = mem_wdata;
        ng++;
      end
    end
    req = '0;
    check("t2_ngrants", 32'(ng), 4);
    check("t2_gnt0", 32'(gseq[0]), 32'h1);
    check("t2_gnt1", 32'(gseq[1]), 32'h2);
    check("t2_gnt2", 32'(gseq[2]), 32'h4);
    check("t2_gnt3", 32'(gseq[3]), 32'h1);
    check("t2_wdata0", 32'(wseq[0]), 32'hC0);
    check("t2_wdata1", 32'(wseq[1]), 32'hC1);
    check("t2_wdata2", 32'(wseq[2]), 32'hC2);
    check("t2_wdata3", 32'(wseq[3]), 32'hC0);

    // Lockout during active video, then stall count latched by frame
    frame_pulse();
    de = 1'b1;
    set_req(0, 1'b0, 12'h010, 8'h00);
    req   = 3'b001;
    gseen = 0;
    for (int t = 0; t < 100; t++) begin
      tick();
      if (gnt != '0) gseen++;
    end
    req = '0;
    frame_pulse();
    check("t3_no_grant", 32'(gseen), 0);
    check("t3_stall_last", 32'(stall_last), 100);
    de = 1'b0;
    tick();

    // Render stream blocks logic until the first idle sample
    set_req(1, 1'b0, 12'h101, 8'h00);
    req     = 3'b010;
    rd_req  = 1'b1;
    rd_addr = 12'h100;
    tick();
    check("t4_gnt_blocked", 32'(gnt), 0);
    check("t4_mem_addr", 32'(mem_addr), 32'h100);
    check("t4_rd_valid_lat1", 32'(rd_valid), 0);
    rd_addr = 12'h102;
    tick();
    check("t4_rd_valid_lat2", 32'(rd_valid), 1);
    check("t4_rd_data", 32'(rd_data), 32'hC0);
    for (int t = 0; t < 6; t++) begin
      rd_addr = ADDRW'(12'h010 + t);
      tick();
      check("t4_gnt_held", 32'(gnt), 0);
      check("t4_stream", 32'(rd_valid), 1);
    end
    rd_req = 1'b0;
    tick();
    check("t4_gnt", 32'(gnt), 32'h2);
    check("t4_stream_tail", 32'(rd_valid), 1);
    tick();
    check("t4_done", 32'(done), 32'h2);
    check("t4_rdata", 32'(req_rdata), 32'hC1);
    req = '0;
    tick(); tick();

    // Reset while a grant is on the port
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, ADDRW'(12'h010 + i), 8'h00);
    req = 3'b111;
    tick();
    check("t5_gnt_before", 32'(gnt), 32'h4);
    rst_n = 1'b0;
    tick();
    check("t5_rst_gnt", 32'(gnt), 0);
    check("t5_rst_done", 32'(done), 0);
    check("t5_rst_mem_en", 32'(mem_en), 0);
    check("t5_rst_rd_valid", 32'(rd_valid), 0);
    rst_n = 1'b1;
    req   = '0;
    frame_pulse();
    check("t5_no_done", 32'(done), 0);
    req = 3'b111;
    tick();
    check("t5_gnt_after", 32'(gnt), 32'h1);
    tick();
    check("t5_done_after", 32'(done), 32'h1);
    req = '0;
    tick(); tick();

`ifdef VRAM_ARB_VBLANK_ONLY_EN
    // Horizontal blanking after line is closed to logic until frame
    set_req(0, 1'b0, 12'h010, 8'h00);
    line = 1'b1;
    req  = 3'b001;
    tick();
    line  = 1'b0;
    gseen = (gnt != '0) ? 1 : 0;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (gnt != '0) gseen++;
    end
    check("t6_hblank_closed", 32'(gseen), 0);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    check("t6_gnt_after_frame", 32'(gnt), 32'h1);
    tick();
    req = '0;
    tick(); tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
